matrix_3x3_window_8bit: RTL and testbench

- Consumes the three row taps of the 8-bit line-shift RAM and builds a registered 3x3 pixel neighbourhood for downstream filters (Sobel, median, erosion).
- Aligns frame syncs with the tap latency of the line buffer.
- Tracks row and column position and flags windows that are not fully populated (frame border).
- Sits between the line-shift RAM and any 3x3 kernel stage in the VIP chain.

---
 rtl/matrix_3x3_window_8bit.sv | 208 ++++++++++++++++++++
 tb/tb_matrix_3x3_window_8bit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_3x3_window_8bit.sv
// 3x3 pixel neighbourhood builder behind the 8-bit line-shift RAM, with sync realignment and border flag.
// Optional build macro MATRIX_BORDER_ZERO_EN: forces all nine matrix outputs to 0 on border windows.
module matrix_3x3_window_8bit #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int TAP_LAT   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] taps0x,
    input  logic [7:0] taps1x,
    input  logic [7:0] taps2x,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] matrix_p11,
    output logic [7:0] matrix_p12,
    output logic [7:0] matrix_p13,
    output logic [7:0] matrix_p21,
    output logic [7:0] matrix_p22,
    output logic [7:0] matrix_p23,
    output logic [7:0] matrix_p31,
    output logic [7:0] matrix_p32,
    output logic [7:0] matrix_p33,
    output logic       post_border
);

    localparam int CW = $clog2(IMG_HDISP) + 1;
    localparam int RW = $clog2(IMG_VDISP) + 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);

`ifdef MATRIX_BORDER_ZERO_EN
    localparam bit BORDER_ZERO = 1'b1;
`else
    localparam bit BORDER_ZERO = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   frame_s;

    logic [TAP_LAT-1:0] vsync_dly_r;
    logic [TAP_LAT-1:0] href_dly_r;
    logic [TAP_LAT-1:0] clken_dly_r;
    logic a_vsync_s;
    logic a_href_s;
    logic a_clken_s;
    logic a_vsync_d_r;
    logic a_href_d_r;
    logic vsync_rise_s;
    logic href_fall_s;
    logic shift_en_s;
    logic border_nxt_s;

    logic [CW-1:0] col_cnt_r;
    logic [RW-1:0] row_cnt_r;

    // Index [2] is column x (newest), [0] is column x-2 (oldest).
    logic [2:0][7:0] top_r, mid_r, bot_r;
    logic [2:0][7:0] top_nxt_s, mid_nxt_s, bot_nxt_s;
    logic [2:0][7:0] top_out_r, mid_out_r, bot_out_r;

    assign a_vsync_s    = vsync_dly_r[TAP_LAT-1];
    assign a_href_s     = href_dly_r[TAP_LAT-1];
    assign a_clken_s    = clken_dly_r[TAP_LAT-1];
    assign vsync_rise_s = a_vsync_s & ~a_vsync_d_r;
    assign href_fall_s  = ~a_href_s & a_href_d_r;
    assign shift_en_s   = a_clken_s & frame_s;
    assign border_nxt_s = (row_cnt_r < RW'(2)) || (col_cnt_r < CW'(2));
    assign top_nxt_s    = {taps0x, top_r[2], top_r[1]};
    assign mid_nxt_s    = {taps1x, mid_r[2], mid_r[1]};
    assign bot_nxt_s    = {taps2x, bot_r[2], bot_r[1]};

    // Sync delay line matching the line-buffer tap latency, plus edge-detect history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_dly_r <= '0;
            href_dly_r  <= '0;
            clken_dly_r <= '0;
            a_vsync_d_r <= 1'b0;
            a_href_d_r  <= 1'b0;
        end else begin
            vsync_dly_r[0] <= per_frame_vsync;
            href_dly_r[0]  <= per_frame_href;
            clken_dly_r[0] <= per_frame_clken;
            for (int i = 1; i < TAP_LAT; i++) begin
                vsync_dly_r[i] <= vsync_dly_r[i-1];
                href_dly_r[i]  <= href_dly_r[i-1];
                clken_dly_r[i] <= clken_dly_r[i-1];
            end
            a_vsync_d_r <= a_vsync_s;
            a_href_d_r  <= a_href_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: FRAME is left only through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = vsync_rise_s ? ST_FRAME : ST_IDLE;
            ST_FRAME: state_nxt_s = ST_FRAME;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        frame_s = 1'b0;
        case (state_r)
            ST_FRAME: frame_s = 1'b1;
            ST_IDLE:  frame_s = 1'b0;
            default:  frame_s = 1'b0;
        endcase
    end

    // Row/column position; vsync clear takes priority over the end-of-line increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_cnt_r <= '0;
            row_cnt_r <= '0;
        end else if (!frame_s) begin
            col_cnt_r <= '0;
            row_cnt_r <= '0;
        end else begin
            if (!a_href_s) begin
                col_cnt_r <= '0;
            end else if (a_clken_s && (col_cnt_r != COL_MAX)) begin
                col_cnt_r <= col_cnt_r + CW'(1);
            end
            if (vsync_rise_s) begin
                row_cnt_r <= '0;
            end else if (href_fall_s && (row_cnt_r != ROW_MAX)) begin
                row_cnt_r <= row_cnt_r + RW'(1);
            end
        end
    end

    // Raw window shift registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            top_r <= '0;
            mid_r <= '0;
            bot_r <= '0;
        end else if (shift_en_s) begin
            top_r <= top_nxt_s;
            mid_r <= mid_nxt_s;
            bot_r <= bot_nxt_s;
        end
    end

    // Registered outputs, updated together with post_frame_clken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_border      <= 1'b0;
            top_out_r        <= '0;
            mid_out_r        <= '0;
            bot_out_r        <= '0;
        end else begin
            post_frame_vsync <= a_vsync_s;
            post_frame_href  <= a_href_s & frame_s;
            post_frame_clken <= shift_en_s;
            if (shift_en_s) begin
                post_border <= border_nxt_s;
                if (BORDER_ZERO && border_nxt_s) begin
                    top_out_r <= '0;
                    mid_out_r <= '0;
                    bot_out_r <= '0;
                end else begin
                    top_out_r <= top_nxt_s;
                    mid_out_r <= mid_nxt_s;
                    bot_out_r <= bot_nxt_s;
                end
            end
        end
    end

    assign matrix_p11 = top_out_r[0];
    assign matrix_p12 = top_out_r[1];
    assign matrix_p13 = top_out_r[2];
    assign matrix_p21 = mid_out_r[0];
    assign matrix_p22 = mid_out_r[1];
    assign matrix_p23 = mid_out_r[2];
    assign matrix_p31 = bot_out_r[0];
    assign matrix_p32 = bot_out_r[1];
    assign matrix_p33 = bot_out_r[2];

endmodule

// File: tb/tb_matrix_3x3_window_8bit.sv
// Self-checking bench for matrix_3x3_window_8bit: frame-level model plus hand-computed checkpoints.
module tb_matrix_3x3_window_8bit;

    localparam int H   = 8;
    localparam int V   = 8;
    localparam int TL  = 3;
    localparam int LAT = TL + 1;
    localparam int N   = 2048;

`ifdef MATRIX_BORDER_ZERO_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
    logic [7:0] taps0x = 8'd0, taps1x = 8'd0, taps2x = 8'd0;
    logic post_frame_vsync, post_frame_href, post_frame_clken, post_border;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    matrix_3x3_window_8bit #(.IMG_HDISP(H), .IMG_VDISP(V), .TAP_LAT(TL)) dut (
        .clock(clock), .reset(reset),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken),
        .taps0x(taps0x), .taps1x(taps1x), .taps2x(taps2x),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .post_border(post_border)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected outputs indexed by the cycle in which they must be visible.
    bit e_vs[N], e_hr[N], e_ck[N], e_bd[N];
    int e_mat[N][9];
    int tq0[N], tq1[N], tq2[N];

    // Frame-level model state: pixel position and the last three pixels of each row.
    bit m_frame, m_pvs, m_phr, m_border;
    int m_row, m_col;
    int m_win[9];

    int n_pass = 0, n_total = 0;
    int first_in = -1, first_post = -1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_step(input int n, input bit r, input bit vs, input bit hr, input bit ck,
                              input int t0, input int t1, input int t2);
        bit active;
        if (r) begin
            for (int k = 0; k <= LAT; k++) begin
                e_vs[n+k] = 1'b0; e_hr[n+k] = 1'b0; e_ck[n+k] = 1'b0; e_bd[n+k] = 1'b0;
                for (int j = 0; j < 9; j++) e_mat[n+k][j] = 0;
            end
            m_frame = 1'b0; m_pvs = 1'b0; m_phr = 1'b0; m_border = 1'b0;
            m_row = 0; m_col = 0;
            for (int j = 0; j < 9; j++) m_win[j] = 0;
        end else begin
            active = m_frame;
            e_vs[n+LAT] = vs;
            e_hr[n+LAT] = hr && active;
            e_ck[n+LAT] = ck && active;
            if (active && ck) begin
                if (first_in < 0) first_in = n;
                m_border = (m_row < 2) || (m_col < 2);
                for (int rr = 0; rr < 3; rr++) begin
                    m_win[rr*3]   = m_win[rr*3+1];
                    m_win[rr*3+1] = m_win[rr*3+2];
                end
                m_win[2] = t0; m_win[5] = t1; m_win[8] = t2;
            end
            if (active) begin
                if (!hr) m_col = 0;
                else if (ck && m_col < H - 1) m_col++;
                if (vs && !m_pvs) m_row = 0;
                else if (!hr && m_phr && m_row < V - 1) m_row++;
            end
            if (vs && !m_pvs) m_frame = 1'b1;
            e_bd[n+LAT] = m_border;
            for (int j = 0; j < 9; j++) e_mat[n+LAT][j] = (ZERO && m_border) ? 0 : m_win[j];
            m_pvs = vs;
            m_phr = hr;
        end
    endtask

    // Drive one cycle of inputs; taps arrive TAP_LAT cycles after their clken, as from the line buffer.
    task automatic drive(input bit r, input bit vs, input bit hr, input bit ck,
                         input int t0, input int t1, input int t2);
        int n;
        n = cyc;
        reset = r;
        per_frame_vsync = vs; per_frame_href = hr; per_frame_clken = ck;
        tq0[n+TL] = t0; tq1[n+TL] = t1; tq2[n+TL] = t2;
        taps0x = 8'(tq0[n]); taps1x = 8'(tq1[n]); taps2x = 8'(tq2[n]);
        model_step(n, r, vs, hr, ck, t0, t1, t2);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic vsync_pulse();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(4);
    endtask

    task automatic pix(input int from, input int to, input int t0, input int t1,
                       input int t2b, input int inc);
        for (int i = from; i <= to; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, t0, t1, t2b + i * inc);
    endtask

    task automatic hold(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic line8(input int t0, input int t1, input int t2);
        pix(0, 7, t0, t1, t2, 0);
        idle(4);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (cyc < N) begin
            check("sync", {post_frame_vsync, post_frame_href, post_frame_clken},
                  {e_vs[cyc], e_hr[cyc], e_ck[cyc]});
            check("border", post_border, e_bd[cyc]);
            check("row_top", {matrix_p11, matrix_p12, matrix_p13},
                  (e_mat[cyc][0] << 16) | (e_mat[cyc][1] << 8) | e_mat[cyc][2]);
            check("row_mid", {matrix_p21, matrix_p22, matrix_p23},
                  (e_mat[cyc][3] << 16) | (e_mat[cyc][4] << 8) | e_mat[cyc][5]);
            check("row_bot", {matrix_p31, matrix_p32, matrix_p33},
                  (e_mat[cyc][6] << 16) | (e_mat[cyc][7] << 8) | e_mat[cyc][8]);
            if (post_frame_clken && first_post < 0) first_post = cyc;
        end
    end

    initial begin
        @(posedge clock);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("reset_href", post_frame_href, 0);
        check("reset_p33", matrix_p33, 0);
        idle(3);

        // Activity without vsync must stay suppressed.
        pix(0, 3, 5, 6, 7, 1);
        hold(6);
        check("idle_clken", post_frame_clken, 0);
        check("idle_href", post_frame_href, 0);
        check("idle_p33", matrix_p33, 0);
        idle(4);

        // Row 0 ramp: taps2x = 10..17.
        vsync_pulse();
        pix(0, 2, 0, 0, 10, 1);
        hold(6);
        check("lat_first_clken", first_post - first_in, 4);
        check("ramp_border", post_border, 1);
        check("model_p33", e_mat[cyc][8], ZERO ? 0 : 12);
        check("ramp_p31", matrix_p31, ZERO ? 0 : 10);
        check("ramp_p32", matrix_p32, ZERO ? 0 : 11);
        check("ramp_p33", matrix_p33, ZERO ? 0 : 12);
        check("ramp_p23", matrix_p23, 0);
        pix(3, 7, 0, 0, 10, 1);
        idle(4);

        // Constant three-line frame.
        vsync_pulse();
        line8(1, 2, 3);
        line8(1, 2, 3);
        pix(0, 4, 1, 2, 3, 0);
        hold(6);
        check("const_border", post_border, 0);
        check("model_p22", e_mat[cyc][4], 2);
        check("const_top", {matrix_p11, matrix_p12, matrix_p13}, 32'h010101);
        check("const_mid", {matrix_p21, matrix_p22, matrix_p23}, 32'h020202);
        check("const_bot", {matrix_p31, matrix_p32, matrix_p33}, 32'h030303);
        pix(5, 7, 1, 2, 3, 0);
        idle(4);

        // Over-long line: column counter saturates, window stays valid.
        pix(0, 11, 1, 2, 20, 1);
        hold(6);
        check("sat_border", post_border, 0);
        check("sat_bot", {matrix_p31, matrix_p32, matrix_p33}, (29 << 16) | (30 << 8) | 31);
        check("sat_top", {matrix_p11, matrix_p12, matrix_p13}, 32'h010101);
        idle(4);

        // Row 4, then reset during row 5.
        line8(1, 2, 3);
        pix(0, 2, 4, 5, 7, 1);
        hold(6);
        check("row5_p33", matrix_p33, 9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("midrst_href", post_frame_href, 0);
        check("midrst_p33", matrix_p33, 0);
        check("midrst_p11", matrix_p11, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle(3);
        pix(0, 7, 1, 2, 3, 0);
        hold(6);
        check("postrst_href", post_frame_href, 0);
        check("postrst_clken", post_frame_clken, 0);
        idle(4);

        // New frame restarts the row count; coincident href fall and vsync rise clears it.
        vsync_pulse();
        pix(0, 4, 1, 2, 3, 0);
        hold(6);
        check("restart_border", post_border, 1);
        check("restart_p33", matrix_p33, ZERO ? 0 : 3);
        pix(5, 7, 1, 2, 3, 0);
        idle(4);
        pix(0, 7, 4, 5, 6, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(4);
        pix(0, 4, 1, 2, 3, 0);
        hold(6);
        check("coinc_border", post_border, 1);
        pix(5, 7, 1, 2, 3, 0);
        idle(4);
        line8(1, 2, 3);
        pix(0, 4, 7, 8, 9, 0);
        hold(6);
        check("row2_border", post_border, 0);
        check("row2_p22", matrix_p22, 8);
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
